// File: rtl/paicore_xfer_ctrl_pkg.sv
// Shared types for the PAICORE transfer sequencer.
// State codes match the register-file status encoding.
package paicore_xfer_ctrl_pkg;

    typedef enum logic [1:0] {
        XFER_IDLE = 2'd0,
        XFER_SEND = 2'd1,
        XFER_RECV = 2'd2
    } xfer_state_e;

endpackage

// File: rtl/paicore_us_timer.sv
// Microsecond tick source: prescaler over clk plus a saturating us counter.
// Holds its value whenever run is low.
module paicore_us_timer #(
    parameter int CNT_WIDTH = 32,
    parameter int US_CYCLES = 100
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 run,
    output logic [CNT_WIDTH-1:0] us_cnt
);

    localparam int PW = (US_CYCLES > 2) ? $clog2(US_CYCLES) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(US_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [PW-1:0] pre_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q  <= '0;
            us_cnt <= '0;
        end else if (clear) begin
            pre_q  <= '0;
            us_cnt <= '0;
        end else if (run) begin
            if (pre_q == PRE_LAST) begin
                pre_q <= '0;
                if (us_cnt != CNT_MAX) begin
                    us_cnt <= us_cnt + CNT_WIDTH'(1);
                end
            end else begin
                pre_q <= pre_q + PW'(1);
            end
        end
    end

endmodule

// File: rtl/paicore_xfer_ctrl.sv
// PAICORE transaction sequencer: send phase, then frame-counted receive
// phase with an optional microsecond timeout.
module paicore_xfer_ctrl
    import paicore_xfer_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 32,
    parameter int US_CYCLES = 100
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CNT_WIDTH-1:0] send_len,
    input  logic [CNT_WIDTH-1:0] frame_num_max,
    input  logic [CNT_WIDTH-1:0] timeout_us,
    input  logic                 tx_beat,
    input  logic                 rx_beat,
    input  logic                 rx_last,
    output logic                 tx_en,
    output logic                 rx_en,
    output logic                 busy,
    output logic                 tx_done,
    output logic                 rx_done,
    output logic                 timeout,
    output logic [CNT_WIDTH-1:0] rx_frame_cnt,
    output logic [CNT_WIDTH-1:0] us_tick_num
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    xfer_state_e state_q, state_d;

    logic [CNT_WIDTH-1:0] tx_cnt_q, tx_cnt_d;
    logic [CNT_WIDTH-1:0] frame_q, frame_d;
    logic [CNT_WIDTH-1:0] tx_inc, frame_inc;
    logic tx_done_q, tx_done_d;
    logic rx_done_q, rx_done_d;
    logic timeout_q, timeout_d;
    logic timer_clear;
    logic frame_end, frame_hit, timed_out;

    assign tx_inc = (tx_cnt_q == CNT_MAX) ? tx_cnt_q
                  : tx_cnt_q + CNT_WIDTH'(1);
    assign frame_inc = (frame_q == CNT_MAX) ? frame_q
                     : frame_q + CNT_WIDTH'(1);

    assign frame_end = rx_beat & rx_last;
    // Normal completion outranks the timeout when both land together.
    assign frame_hit = (frame_num_max == '0)
                     | (frame_end & (frame_inc == frame_num_max));
    assign timed_out = (timeout_us != '0) & (us_tick_num >= timeout_us);

    always_comb begin
        state_d     = state_q;
        tx_cnt_d    = tx_cnt_q;
        frame_d     = frame_q;
        tx_done_d   = tx_done_q;
        rx_done_d   = rx_done_q;
        timeout_d   = timeout_q;
        timer_clear = 1'b0;
        if (abort) begin
            state_d   = XFER_IDLE;
            tx_done_d = 1'b0;
            rx_done_d = 1'b0;
            timeout_d = 1'b0;
        end else begin
            unique case (state_q)
                XFER_IDLE: begin
                    if (start) begin
                        timer_clear = 1'b1;
                        tx_cnt_d    = '0;
                        frame_d     = '0;
                        rx_done_d   = 1'b0;
                        timeout_d   = 1'b0;
                        if (send_len == '0) begin
                            state_d   = XFER_RECV;
                            tx_done_d = 1'b1;
                        end else begin
                            state_d   = XFER_SEND;
                            tx_done_d = 1'b0;
                        end
                    end
                end
                XFER_SEND: begin
                    if (tx_beat) begin
                        tx_cnt_d = tx_inc;
                        if (tx_inc == send_len) begin
                            state_d   = XFER_RECV;
                            tx_done_d = 1'b1;
                        end
                    end
                end
                XFER_RECV: begin
                    if (frame_end) begin
                        frame_d = frame_inc;
                    end
                    if (frame_hit) begin
                        state_d   = XFER_IDLE;
                        rx_done_d = 1'b1;
                    end else if (timed_out) begin
                        state_d   = XFER_IDLE;
                        rx_done_d = 1'b1;
                        timeout_d = 1'b1;
                    end
                end
                default: state_d = XFER_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= XFER_IDLE;
            tx_cnt_q  <= '0;
            frame_q   <= '0;
            tx_done_q <= 1'b0;
            rx_done_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_cnt_q  <= tx_cnt_d;
            frame_q   <= frame_d;
            tx_done_q <= tx_done_d;
            rx_done_q <= rx_done_d;
            timeout_q <= timeout_d;
        end
    end

    paicore_us_timer #(
        .CNT_WIDTH (CNT_WIDTH),
        .US_CYCLES (US_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .run    (busy),
        .us_cnt (us_tick_num)
    );

    assign tx_en        = (state_q == XFER_SEND);
    assign rx_en        = (state_q == XFER_RECV);
    assign busy         = tx_en | rx_en;
    assign tx_done      = tx_done_q;
    assign rx_done      = rx_done_q;
    assign timeout      = timeout_q;
    assign rx_frame_cnt = frame_q;

endmodule
